// File: rtl/memory_map_pkg.sv
// Shared constants, target-select type and address decode for the CPU data-port memory map.
package memory_map_pkg;
   localparam logic [15:0] ADDR_BTN      = 16'h2000;
   localparam logic [15:0] ADDR_LED      = 16'h2001;
   localparam int          RAM_ADDR_BITS = 13;
   localparam logic [15:0] RAM_TOP       = 16'h1FFF;

   typedef enum logic [1:0] {
      SEL_RAM,
      SEL_BTN,
      SEL_LED,
      SEL_NONE
   } sel_t;

   // RAM window holes above a shallow RAM_WORDS decode as unmapped.
   function automatic sel_t decode(input logic [15:0] address, input int ram_words);
      sel_t sel;
      sel = SEL_NONE;
      if (address <= RAM_TOP) begin
         if (int'(address) < ram_words) sel = SEL_RAM;
      end else if (address == ADDR_BTN) begin
         sel = SEL_BTN;
      end else if (address == ADDR_LED) begin
         sel = SEL_LED;
      end
      return sel;
   endfunction
endpackage

// File: rtl/memory_map_ram8k.sv
// Single-port word RAM: asynchronous read, synchronous write, contents never reset.
module ram8k #(
   parameter int WORDS = 8192
) (
   input  logic        clk,
   input  logic        we,
   input  logic [12:0] addr,
   input  logic [15:0] din,
   output logic [15:0] dout
);
   localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic [15:0]   mem [WORDS];
   logic [AW-1:0] idx;

   assign idx  = addr[AW-1:0];
   assign dout = mem[idx];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= din;
   end
endmodule

// File: rtl/memory_map.sv
// Data-port address decoder: RAM, synchronized push-button word and LED register.
module memory_map
   import memory_map_pkg::*;
#(
   parameter int RAM_WORDS = 8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] address,
   input  logic        load,
   input  logic [15:0] in,
   output logic [15:0] out,
   input  logic        btn,
   output logic        led
);
   sel_t        sel;
   logic        ram_we;
   logic [15:0] ram_dout;
   logic        led_reg;
   logic        btn_meta;
   logic        btn_sync;

   assign sel = decode(address, RAM_WORDS);

   // Writes are suppressed while reset is held so a RAM write only lands with rst_n high at the edge.
   assign ram_we = load && rst_n && (sel == SEL_RAM);

   ram8k #(
      .WORDS(RAM_WORDS)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (address[RAM_ADDR_BITS-1:0]),
      .din  (in),
      .dout (ram_dout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_reg <= 1'b0;
      end else if (load && (sel == SEL_LED)) begin
         led_reg <= in[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         btn_meta <= btn;
         btn_sync <= btn_meta;
      end
   end

   assign led = led_reg;

   always_comb begin
      out = 16'h0000;
      case (sel)
         SEL_RAM:  out = ram_dout;
         SEL_BTN:  out = {15'b0, btn_sync};
         SEL_LED:  out = {15'b0, led_reg};
         default:  out = 16'h0000;
      endcase
   end
endmodule

// File: tb/tb_memory_map.sv
// Randomized scoreboard bench for memory_map against an address-map reference model.
module tb_memory_map;
   logic        clk;
   logic        rst_n;
   logic [15:0] address;
   logic        load;
   logic [15:0] in;
   logic [15:0] out;
   logic        btn;
   logic        led;

   memory_map #(.RAM_WORDS(8192)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .address (address),
      .load    (load),
      .in      (in),
      .out     (out),
      .btn     (btn),
      .led     (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] out;
      logic        led;
      bit          care_out;
      logic [15:0] addr;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;

   // Reference model state
   logic [15:0] m_ram [int];
   logic        m_led;
   logic        m_s1;
   logic        m_s2;

   function automatic exp_t expect_for(input logic [15:0] a);
      exp_t e;
      e.addr     = a;
      e.led      = m_led;
      e.care_out = 1'b1;
      e.out      = 16'h0000;
      if (a < 16'h2000) begin
         if (m_ram.exists(int'(a))) e.out = m_ram[int'(a)];
         else e.care_out = 1'b0;
      end else if (a == 16'h2000) begin
         e.out = {15'b0, m_s2};
      end else if (a == 16'h2001) begin
         e.out = {15'b0, m_led};
      end
      return e;
   endfunction

   // Called at posedge+1: drive inputs, queue the expected response, then cross one edge.
   task automatic cycle(input logic [15:0] a, input logic l, input logic [15:0] d, input logic b);
      address = a;
      load    = l;
      in      = d;
      btn     = b;
      sb.push_back(expect_for(a));
      @(posedge clk);
      if (!rst_n) begin
         m_led = 1'b0;
         m_s1  = 1'b0;
         m_s2  = 1'b0;
      end else begin
         if (l && a < 16'h2000) m_ram[int'(a)] = d;
         if (l && a == 16'h2001) m_led = d[0];
         m_s2 = m_s1;
         m_s1 = b;
      end
      #1;
   endtask

   task automatic mid_reset();
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (led !== 1'b0) begin
         failures++;
         $display("FAIL reset_led_async: got %b want 0 at %0t", led, $time);
      end
      m_led = 1'b0;
      m_s1  = 1'b0;
      m_s2  = 1'b0;
   endtask

   // Monitor: the DUT output is combinational, sampled mid-cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.care_out) begin
               checks++;
               if (out !== e.out) begin
                  failures++;
                  $display("FAIL out@%h: got %h want %h at %0t", e.addr, out, e.out, $time);
               end
            end
            checks++;
            if (led !== e.led) begin
               failures++;
               $display("FAIL led: got %b want %b at %0t", led, e.led, $time);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] a;
      int          r;
      rst_n   = 1'b0;
      address = 16'h0000;
      load    = 1'b0;
      in      = 16'h0000;
      btn     = 1'b0;
      m_led   = 1'b0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset behaviour, including a blocked LED write while reset is held
      cycle(16'h2001, 1'b1, 16'h0001, 1'b0);
      mid_reset();
      cycle(16'h2001, 1'b1, 16'h0001, 1'b0);
      rst_n = 1'b1;
      cycle(16'h2001, 1'b0, 16'h0000, 1'b0);

      // RAM write/read and overwrite
      cycle(16'h0000, 1'b1, 16'hFFFF, 1'b0);
      cycle(16'h0000, 1'b0, 16'd9999, 1'b0);
      cycle(16'h0000, 1'b1, 16'd12345, 1'b0);
      cycle(16'h0000, 1'b0, 16'd9999, 1'b0);
      cycle(16'd1200, 1'b1, 16'h0BAD, 1'b0);
      cycle(16'd1000, 1'b1, 16'd2222, 1'b0);
      cycle(16'd1000, 1'b0, 16'd9999, 1'b0);
      cycle(16'h0000, 1'b0, 16'd9999, 1'b0);
      cycle(16'd1200, 1'b0, 16'd9999, 1'b0);

      // RAM write held off by reset, then applied
      mid_reset();
      cycle(16'd1200, 1'b1, 16'h5555, 1'b0);
      rst_n = 1'b1;
      cycle(16'd1200, 1'b0, 16'h0000, 1'b0);

      // LED register, bit 0 only
      cycle(16'h2001, 1'b1, 16'h0001, 1'b0);
      cycle(16'h2001, 1'b1, 16'h0000, 1'b0);
      cycle(16'h2001, 1'b1, 16'hFFFE, 1'b0);
      cycle(16'h2001, 1'b0, 16'h0000, 1'b0);

      // Button through the synchronizer; writes to it ignored
      for (int i = 0; i < 3; i++) cycle(16'h2000, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) cycle(16'h2000, 1'b1, 16'd12345, 1'b0);

      // Unmapped reads and ignored writes
      cycle(16'h0002, 1'b1, 16'h0A0A, 1'b0);
      cycle(16'h1FFF, 1'b1, 16'hB0B0, 1'b0);
      cycle(16'h2001, 1'b1, 16'h0001, 1'b0);
      cycle(16'h2002, 1'b1, 16'h1234, 1'b0);
      cycle(16'hFFFF, 1'b1, 16'h1234, 1'b0);
      cycle(16'h0002, 1'b0, 16'h0000, 1'b0);
      cycle(16'h1FFF, 1'b0, 16'h0000, 1'b0);
      cycle(16'h2001, 1'b0, 16'h0000, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40)      a = 16'($urandom_range(0, 31));
         else if (r < 50) a = 16'($urandom_range(8176, 8191));
         else if (r < 65) a = 16'h2000;
         else if (r < 80) a = 16'h2001;
         else             a = 16'($urandom_range(16'h2002, 16'hFFFF));
         if ($urandom_range(0, 99) == 0) begin
            mid_reset();
            cycle(a, 1'($urandom_range(0, 1)), 16'($urandom), btn);
            rst_n = 1'b1;
         end else begin
            cycle(a, 1'($urandom_range(0, 1)), 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? ~btn : btn);
         end
      end

      load = 1'b0;
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
